// File: rtl/kb_event_rx_pkg.sv
// Shared definitions for the PS/2 key-event receiver: prefix bytes, frame length,
// FSM encodings and the 10-bit event payload.
package kb_event_rx_pkg;

    localparam logic [7:0]  KB_PFX_EXT   = 8'hE0;
    localparam logic [7:0]  KB_PFX_BRK   = 8'hF0;
    localparam int unsigned KB_FRAME_LEN = 11;
    localparam int unsigned KB_EVT_W     = 10;

    typedef enum logic {
        FRM_IDLE = 1'b0,
        FRM_RECV = 1'b1
    } frm_state_e;

    typedef enum logic [1:0] {
        PFX_BASE    = 2'd0,
        PFX_EXT     = 2'd1,
        PFX_BRK     = 2'd2,
        PFX_EXT_BRK = 2'd3
    } pfx_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } kb_evt_t;

    // Odd parity over data + parity bit
    function automatic logic odd_parity_ok(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// DEPTH x 10-bit first-word-fall-through FIFO with registered head, level and sticky overflow.
module kb_event_fifo
    import kb_event_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         i_sclr,
    input  logic                         i_push,
    input  kb_evt_t                      i_data,
    input  logic                         i_pop,
    output logic                         o_valid,
    output kb_evt_t                      o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic                         o_full_c,
    output logic                         o_empty_c,
    output logic                         o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    kb_evt_t         mem_q [DEPTH];
    kb_evt_t         mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            valid_q, valid_d;
    kb_evt_t         head_q, head_d;
    logic            ovf_q, ovf_d;
    logic            push_ok, pop_ok;

    assign o_full_c  = (level_q == LW'(DEPTH));
    assign o_empty_c = (level_q == '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        head_d   = '0;

        pop_ok  = i_pop & ~o_empty_c;
        push_ok = i_push & (~o_full_c | pop_ok);
        ovf_d   = ovf_q | (i_push & ~push_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head is registered, so bypass the write data when it lands in the new head slot
        valid_d = (level_d != '0);
        if (valid_d) begin
            head_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? i_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
        mem_q <= mem_d;
    end

    assign o_valid    = valid_q;
    assign o_head     = head_q;
    assign o_level    = level_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/kb_event_rx.sv
// PS/2 keyboard receiver: clock filter, frame deserialiser with watchdog, E0/F0 prefix folding
// and event FIFO. Define KB_PARITY_CHECK_EN to reject frames with bad odd parity.
module kb_event_rx
    import kb_event_rx_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         i_sclr,
    input  logic                         i_ps2_clk_n,
    input  logic                         i_ps2_dat,
    output logic                         o_evt_valid,
    input  logic                         i_evt_ready,
    output logic [7:0]                   o_evt_code,
    output logic                         o_evt_break,
    output logic                         o_evt_ext,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_level,
    output logic                         o_overflow,
    output logic                         o_frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          edge_q, edge_d;
    frm_state_e    frm_q, frm_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    pfx_state_e    pfx_q, pfx_d;
    logic          parity_ok;
    logic          evt_push;
    kb_evt_t       evt;
    logic          fifo_pop;
    logic          fifo_full_c, fifo_empty_c;
    kb_evt_t       head;

`ifdef KB_PARITY_CHECK_EN
    assign parity_ok = odd_parity_ok(shift_q);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        clk_s1_d     = i_ps2_clk_n;
        clk_s2_d     = clk_s1_q;
        dat_s1_d     = i_ps2_dat;
        dat_s2_d     = dat_s1_q;
        filt_d       = filt_q;
        fcnt_d       = '0;
        frm_d        = frm_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        wd_d         = wd_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        frame_err_d  = 1'b0;
        pfx_d        = pfx_q;
        evt_push     = 1'b0;
        evt.code     = byte_q;
        evt.brk      = (pfx_q == PFX_BRK) || (pfx_q == PFX_EXT_BRK);
        evt.ext      = (pfx_q == PFX_EXT) || (pfx_q == PFX_EXT_BRK);

        // Level changes only after FILTER_LEN consecutive samples disagree with it
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        edge_d = filt_q & ~filt_d;

        case (frm_q)
            FRM_IDLE: begin
                wd_d = '0;
                if (edge_q && !dat_s2_q) begin
                    frm_d     = FRM_RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            FRM_RECV: begin
                if (edge_q) begin
                    wd_d = '0;
                    if (bit_cnt_q == 4'(KB_FRAME_LEN - 1)) begin
                        frm_d = FRM_IDLE;
                        if (dat_s2_q && parity_ok) begin
                            byte_valid_d = 1'b1;
                            byte_d       = shift_q[7:0];
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        shift_d   = {dat_s2_q, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    frm_d       = FRM_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: frm_d = FRM_IDLE;
        endcase

        // Prefix folding: E0/F0 only move state, everything else emits an event
        if (byte_valid_q) begin
            if ((pfx_q == PFX_BASE) && (byte_q == KB_PFX_EXT)) begin
                pfx_d = PFX_EXT;
            end else if ((pfx_q == PFX_BASE) && (byte_q == KB_PFX_BRK)) begin
                pfx_d = PFX_BRK;
            end else if ((pfx_q == PFX_EXT) && (byte_q == KB_PFX_BRK)) begin
                pfx_d = PFX_EXT_BRK;
            end else begin
                evt_push = 1'b1;
                pfx_d    = PFX_BASE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            filt_q       <= 1'b1;
            fcnt_q       <= '0;
            edge_q       <= 1'b0;
            frm_q        <= FRM_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wd_q         <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
            pfx_q        <= PFX_BASE;
        end else begin
            clk_s1_q     <= clk_s1_d;
            clk_s2_q     <= clk_s2_d;
            dat_s1_q     <= dat_s1_d;
            dat_s2_q     <= dat_s2_d;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            edge_q       <= edge_d;
            frm_q        <= frm_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            wd_q         <= wd_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
            pfx_q        <= pfx_d;
        end
    end

    assign fifo_pop = i_evt_ready & ~fifo_empty_c;

    kb_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .i_sclr     (i_sclr),
        .i_push     (evt_push),
        .i_data     (evt),
        .i_pop      (fifo_pop),
        .o_valid    (o_evt_valid),
        .o_head     (head),
        .o_level    (o_fifo_level),
        .o_full_c   (fifo_full_c),
        .o_empty_c  (fifo_empty_c),
        .o_overflow (o_overflow)
    );

    assign o_evt_code  = head.code;
    assign o_evt_break = head.brk;
    assign o_evt_ext   = head.ext;
    assign o_frame_err = frame_err_q;

endmodule
